// File: rtl/button_pkg.sv
// Shared constants and channel FSM state type for the push-button conditioner.
package button_pkg;

   localparam int BTN_C = 0;
   localparam int BTN_U = 1;
   localparam int BTN_L = 2;
   localparam int BTN_R = 3;
   localparam int BTN_D = 4;

   localparam int N_BTN_DEF         = 5;
   localparam int DEBOUNCE_DEF      = 1000000;
   localparam int REPEAT_DELAY_DEF  = 50000000;
   localparam int REPEAT_PERIOD_DEF = 10000000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_HI = 2'd1,
      HELD    = 2'd2,
      WAIT_LO = 2'd3
   } btn_state_t;

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, registered level/press/release.
// Optional auto-repeat of the press pulse under BUTTON_PULSE_GEN_AUTO_REPEAT_EN.
//
// state   | meaning
// IDLE    | accepted level 0, input agrees
// WAIT_HI | input high, counting toward acceptance of a press
// HELD    | accepted level 1, input agrees
// WAIT_LO | input low, counting toward acceptance of a release
module button_debounce_ch
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
   ,
   parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press,
   output logic released
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_TC  = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1, s2;
   btn_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_d, press_d, released_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);
   localparam logic [RW-1:0] REP_ONE   = RW'(1);

   logic [RW-1:0] rep_q, rep_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rep_q <= REP_FIRST;
      else     rep_q <= rep_d;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         level    <= 1'b0;
         press    <= 1'b0;
         released <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         level    <= level_d;
         press    <= press_d;
         released <= released_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      level_d    = level;
      press_d    = 1'b0;
      released_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (s2) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = HELD;
                  level_d = 1'b1;
                  press_d = 1'b1;
               end else begin
                  state_d = WAIT_HI;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         WAIT_HI: begin
            if (!s2) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_TC) begin
               state_d = HELD;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HELD: begin
            if (!s2) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d    = IDLE;
                  level_d    = 1'b0;
                  released_d = 1'b1;
               end else begin
                  state_d = WAIT_LO;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         WAIT_LO: begin
            if (s2) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_TC) begin
               state_d    = IDLE;
               cnt_d      = '0;
               level_d    = 1'b0;
               released_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
      // Repeat timer only runs while staying in HELD; any other cycle rearms it.
      rep_d = REP_FIRST;
      if (state_q == HELD && state_d == HELD) begin
         if (rep_q == '0) begin
            press_d = 1'b1;
            rep_d   = REP_NEXT;
         end else begin
            rep_d = rep_q - REP_ONE;
         end
      end
`endif
   end

endmodule

// File: rtl/button_pulse_gen.sv
// Push-button conditioner: N_BTN independent debounced channels with press/release pulses.
// Auto-repeat of press pulses is enabled by defining BUTTON_PULSE_GEN_AUTO_REPEAT_EN.
module button_pulse_gen
   import button_pkg::*;
#(
   parameter int N_BTN           = N_BTN_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_err
      $error("button_pulse_gen: timing parameters must be >= 1");
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      button_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
         ,
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .raw      (btn_raw[i]),
         .level    (btn_level[i]),
         .press    (btn_press[i]),
         .released (btn_release[i])
      );
   end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen: directed vector tables, reset corner cases, and random
// stimulus against a run-length reference model.
module tb_button_pulse_gen;

   localparam int NB = 5;
   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RP = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] btn_raw = '0;
   logic [NB-1:0] btn_level, btn_press, btn_release;

   int total = 0;
   int bad   = 0;

   button_pulse_gen #(
      .N_BTN(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw),
      .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NB-1:0] raw;
      logic [NB-1:0] lvl;
      logic [NB-1:0] prs;
      logic [NB-1:0] rel;
   } vec_t;

   vec_t vq[$];

`ifdef BUTTON_PULSE_GEN_AUTO_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   // Reference model: accepted level flips once the synchronised input has
   // disagreed with it on DB consecutive edges.
   logic [NB-1:0] m_s1, m_s2, m_lvl, m_prs, m_rel;
   int            m_run[NB];
   int            m_age[NB];

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
      for (int b = 0; b < NB; b++) begin
         m_run[b] = 0;
         m_age[b] = 0;
      end
   endtask

   task automatic model_step(input logic [NB-1:0] raw);
      logic [NB-1:0] s;
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      m_prs = '0;
      m_rel = '0;
      for (int b = 0; b < NB; b++) begin
         if (s[b] != m_lvl[b]) begin
            m_run[b]++;
            if (m_run[b] == DB) begin
               m_lvl[b] = s[b];
               if (s[b]) m_prs[b] = 1'b1;
               else      m_rel[b] = 1'b1;
               m_run[b] = 0;
               m_age[b] = 0;
            end
         end else begin
            if (REP && m_lvl[b]) begin
               if (m_run[b] > 0) m_age[b] = 0;
               else begin
                  m_age[b]++;
                  if (m_age[b] == RD || (m_age[b] > RD && (m_age[b] - RD) % RP == 0))
                     m_prs[b] = 1'b1;
               end
            end
            m_run[b] = 0;
         end
      end
   endtask

   task automatic chk(input string nm, input int idx, input logic [NB-1:0] act,
                      input logic [NB-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0d: got %b expected %b", nm, idx, act, exp);
      end
   endtask

   task automatic step(input logic [NB-1:0] raw);
      btn_raw = raw;
      @(posedge clk);
      model_step(raw);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      btn_raw = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_level", 0, btn_level, '0);
      chk("rst_press", 0, btn_press, '0);
      chk("rst_release", 0, btn_release, '0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   function automatic logic [NB-1:0] rep_exp(input int i, input int p0);
      if (i == p0) return 5'b01000;
      if (REP && i >= p0 + RD && (i - p0 - RD) % RP == 0 && i <= p0 + 52) return 5'b01000;
      return '0;
   endfunction

   initial begin
      vec_t v;
      logic [NB-1:0] r;
      int pcnt;

      // Single press on bit 3, held, released at index 40.
      for (int i = 0; i < 50; i++) begin
         v.raw = (i < 40) ? 5'b01000 : 5'b00000;
         v.lvl = (i >= 5 && i < 45) ? 5'b01000 : 5'b00000;
         v.prs = (i == 5) ? 5'b01000 : 5'b00000;
         if (REP && (i == 25 || i == 33 || i == 41)) v.prs = 5'b01000;
         v.rel = (i == 45) ? 5'b01000 : 5'b00000;
         vq.push_back(v);
      end
      // Bounces of 1, 2 and 3 cycles on bit 2: no activity.
      begin
         logic [14:0] pat;
         pat = 15'b000111000110001;
         for (int i = 0; i < 21; i++) begin
            v.raw = (i < 15 && pat[i]) ? 5'b00100 : 5'b00000;
            v.lvl = '0; v.prs = '0; v.rel = '0;
            vq.push_back(v);
         end
      end
      // Bits 2 and 3 together.
      for (int j = 0; j < 24; j++) begin
         v.raw = (j < 12) ? 5'b01100 : 5'b00000;
         v.lvl = (j >= 5 && j < 17) ? 5'b01100 : 5'b00000;
         v.prs = (j == 5) ? 5'b01100 : 5'b00000;
         v.rel = (j == 17) ? 5'b01100 : 5'b00000;
         vq.push_back(v);
      end

      do_reset();
      foreach (vq[k]) begin
         step(vq[k].raw);
         chk("tbl_level", k, btn_level, vq[k].lvl);
         chk("tbl_press", k, btn_press, vq[k].prs);
         chk("tbl_release", k, btn_release, vq[k].rel);
      end

      // Reset two cycles into WAIT_HI, then release with raw[0] held.
      do_reset();
      for (int i = 0; i < 4; i++) step(5'b00001);
      rst = 1'b1;
      #1;
      chk("rst_async_level", 0, btn_level, '0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(5'b00001);
         chk("rel_rst_press", i, btn_press, (i == 5) ? 5'b00001 : 5'b00000);
         chk("rel_rst_level", i, btn_level, (i >= 5) ? 5'b00001 : 5'b00000);
      end
      // Reset mid-pulse truncates it; button held gives a fresh press later.
      rst = 1'b1;
      btn_raw = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) step(5'b00001);
      chk("pre_trunc_press", 0, btn_press, 5'b00001);
      #2;
      rst = 1'b1;
      #1;
      chk("trunc_press", 0, btn_press, '0);
      chk("trunc_level", 0, btn_level, '0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(5'b00001);
         chk("post_trunc_press", i, btn_press, (i == 5) ? 5'b00001 : 5'b00000);
      end

      // Long hold on bit 3: auto-repeat behaviour (or single press without it).
      do_reset();
      pcnt = 0;
      for (int i = 0; i < 80; i++) begin
         step((i < 59) ? 5'b01000 : 5'b00000);
         chk("hold_press", i, btn_press, rep_exp(i, 5));
         chk("hold_release", i, btn_release, (i == 64) ? 5'b01000 : 5'b00000);
         if (btn_press[3]) pcnt++;
      end
      total++;
      if (pcnt != (REP ? 6 : 1)) begin
         bad++;
         $display("FAIL hold_press_count: got %0d expected %0d", pcnt, REP ? 6 : 1);
      end

      // Random stimulus against the reference model.
      do_reset();
      r = '0;
      for (int i = 0; i < 4000; i++) begin
         for (int b = 0; b < NB; b++)
            if ($urandom_range(0, (i < 2000) ? 5 : 40) == 0) r[b] = ~r[b];
         step(r);
         chk("rnd_level", i, btn_level, m_lvl);
         chk("rnd_press", i, btn_press, m_prs);
         chk("rnd_release", i, btn_release, m_rel);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/button_pulse_gen.md
Name: button_pulse_gen

Overview:
- Input-side conditioner for the board push-buttons; produces the clean events that the LED position logic consumes.
- Raw buttons in; per-button synchronised, debounced level out, plus single-cycle press and release pulses.
- Replaces the ad-hoc "old value vs new value" edge compares in the display logic. The display side only ever sees one pulse per physical press.

Parameters:
- N_BTN, 5, number of button channels (bit order: 0=btnC, 1=btnU, 2=btnL, 3=btnR, 4=btnD).
- DEBOUNCE_CYCLES, 1000000, cycles an input must be stable in the new state before it is accepted (10 ms at 100 MHz). Must be >= 1.
- REPEAT_DELAY, 50000000, cycles from the press pulse to the first auto-repeat pulse. Used only with AUTO_REPEAT_EN.
- REPEAT_PERIOD, 10000000, cycles between later auto-repeat pulses. Used only with AUTO_REPEAT_EN.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- btn_raw  input  N_BTN  raw, asynchronous button levels; 1 = pressed.
- btn_level  output  N_BTN  debounced level, registered.
- btn_press  output  N_BTN  one-cycle pulse on each accepted 0->1 transition (and on each auto-repeat when that feature is enabled).
- btn_release  output  N_BTN  one-cycle pulse on each accepted 1->0 transition.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - All outputs 0.
  - Synchroniser flops 0, counters 0, every channel FSM in IDLE.
- Synchroniser: two flops per bit; s = second stage.
- Channels are fully independent. Simultaneous events on several channels give pulses in the same cycle.
- Per-channel FSM states and transitions:
  - IDLE (level 0): s=1 -> WAIT_HI with cnt=1.
  - WAIT_HI: s=0 -> IDLE with cnt=0 (glitch rejected, no pulse). s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD. Otherwise cnt++.
  - HELD (level 1): s=0 -> WAIT_LO with cnt=1.
  - WAIT_LO: s=1 -> HELD with cnt=0. s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt++.
  - Special case DEBOUNCE_CYCLES==1: the transition out of IDLE/HELD goes directly to the opposite stable state.
- Outputs on state change:
  - Entering HELD: btn_level<=1 and btn_press<=1 on the same edge.
  - Entering IDLE from WAIT_LO: btn_level<=0 and btn_release<=1.
  - Pulses are cleared on the next edge, so they are exactly one cycle wide.
- Latency: raw first sampled high at edge k and held -> btn_level and btn_press become 1 after edge k+1+DEBOUNCE_CYCLES. Release is symmetric.
- Counter width is $clog2(DEBOUNCE_CYCLES+1). The counter never wraps; it saturates at the compare point by construction.
- Any bounce shorter than DEBOUNCE_CYCLES produces no output activity.
- A button held through reset deassertion gives a press pulse after the normal debounce latency, because level restarts from 0.
- Reset asserted mid-pulse truncates the pulse immediately. No pulse is emitted after reset releases unless a new debounce completes.

Optional Feature:
- Macro: BUTTON_PULSE_GEN_AUTO_REPEAT_EN.
- Defined:
  - While in HELD, a per-channel repeat counter starts at the press pulse.
  - First extra btn_press pulse after REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles.
  - Leaving HELD clears the counter immediately; no repeat pulse is issued in the WAIT_LO cycles.
  - A repeat pulse never coincides with a release pulse.
- Not defined: exactly one btn_press per accepted press; no repeat counters are synthesised.

Decomposition:
- Package button_pkg holds:
  - Channel index constants BTN_C=0, BTN_U=1, BTN_L=2, BTN_R=3, BTN_D=4.
  - The FSM state typedef (IDLE, WAIT_HI, HELD, WAIT_LO).
  - Default timing constants.
- Sub-module button_debounce_ch: one channel (synchroniser, FSM, counter, optional repeat). The top instantiates N_BTN copies in a generate loop.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset, then raw[3]=1 sampled at edge 0 and held -> btn_level[3] and btn_press[3] go 1 after edge 5. btn_press[3] is low after edge 6. No activity on other bits.
- raw[2] pulses of 1, 2 and 3 cycles separated by 3-cycle lows -> no btn_press, btn_level or btn_release on bit 2.
- Held bit 3 then raw[3]=0 sampled at edge 40 -> btn_release[3] is 1 for exactly one cycle after edge 45, and btn_level[3] is 0 from then on.
- raw[2] and raw[3] rise on the same edge -> btn_press[2] and btn_press[3] assert in the same cycle.
- rst asserted two cycles into WAIT_HI, then released with raw[0] held -> outputs go 0 asynchronously. One press pulse follows 5 cycles after the first sampling edge following release.
- With BUTTON_PULSE_GEN_AUTO_REPEAT_EN, hold raw[3] 60 cycles past the press pulse -> press pulses at +0, +20, +28, +36, +44, +52. No repeat pulse after release; exactly one pulse without the macro.
